// File: rtl/goertzel_fx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : goertzel_fx
// Brief    : Fixed-point Goertzel single-bin power detector with one shared
//            multiplier and a sample/power valid-ready style interface.
// Revision : 1.0 - initial release
// ============================================================================
module goertzel_fx #(
    parameter int SAMPLE_W   = 16,
    parameter int COEFF_W    = 18,
    parameter int COEFF_FRAC = 16,
    parameter int STATE_W    = 40,
    parameter int BLOCK_LEN  = 520,
    parameter int POWER_W    = 2*STATE_W
) (
    input  logic                       clock,
    input  logic                       aclr,
    input  logic                       clear,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [COEFF_W-1:0]  coeff,
    output logic [POWER_W-1:0]         power,
    output logic                       power_valid,
    output logic                       overflow
);

    localparam int c_CNT_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam int c_B_W   = (STATE_W > COEFF_W) ? STATE_W : COEFF_W;
    localparam int c_M_W   = 2*STATE_W + c_B_W;
    localparam int c_P_W   = COEFF_W + STATE_W;
    localparam int c_Q_W   = STATE_W + 2;
    localparam int c_MM_W  = 2*STATE_W;
    localparam int c_R_W   = 2*STATE_W + 2;
    localparam int c_RX_W  = (POWER_W + 1 > c_R_W) ? POWER_W + 1 : c_R_W;

    localparam logic [c_CNT_W-1:0]        c_LAST  = c_CNT_W'(BLOCK_LEN - 1);
    localparam logic signed [STATE_W-1:0] c_Q_MAX = {1'b0, {(STATE_W-1){1'b1}}};
    localparam logic signed [STATE_W-1:0] c_Q_MIN = {1'b1, {(STATE_W-1){1'b0}}};
    localparam logic signed [c_RX_W-1:0]  c_PMAX  = c_RX_W'({POWER_W{1'b1}});

    typedef enum logic [2:0] {
        S_WAIT = 3'd0, S_MUL = 3'd1, S_UPD = 3'd2, S_P1 = 3'd3,
        S_P2   = 3'd4, S_P3  = 3'd5, S_P4  = 3'd6, S_P5 = 3'd7
    } state_t;

    state_t                     r_state, w_next;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic signed [COEFF_W-1:0]  r_coeff;
    logic signed [STATE_W-1:0]  r_q1, r_q2;
    logic [c_CNT_W-1:0]         r_cnt;
    logic signed [c_P_W-1:0]    r_p;
    logic signed [c_MM_W-1:0]   r_m1, r_m2, r_m3;
    logic                       r_blk_ovf;
    logic [POWER_W-1:0]         r_power;
    logic                       r_pv, r_ovf;

    logic signed [c_M_W-1:0]    w_ma, w_mb, w_prod, w_prod_sh;
    logic signed [c_P_W-1:0]    w_p_sh;
    logic signed [c_Q_W-1:0]    w_q0;
    logic                       w_sat;
    logic signed [STATE_W-1:0]  w_q0_clip;
    logic signed [c_R_W-1:0]    w_r;
    logic signed [c_RX_W-1:0]   w_r_x;
    logic                       w_clamp;
    logic [POWER_W-1:0]         w_pow;

    assign sample_ready = (r_state == S_WAIT) && !clear;
    assign power        = r_power;
    assign power_valid  = r_pv;
    assign overflow     = r_ovf;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_state <= S_WAIT;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT:  if (sample_valid) w_next = S_MUL;
                S_MUL:   w_next = S_UPD;
                S_UPD:   w_next = (r_cnt == c_LAST) ? S_P1 : S_WAIT;
                S_P1:    w_next = S_P2;
                S_P2:    w_next = S_P3;
                S_P3:    w_next = S_P4;
                S_P4:    w_next = S_P5;
                S_P5:    w_next = S_WAIT;
                default: w_next = S_WAIT;
            endcase
        end
    end

    // One multiplier serves the recursion (MUL) and all power-phase products.
    always_comb begin
        w_ma = c_M_W'(r_q1);
        w_mb = c_M_W'(r_coeff);
        case (r_state)
            S_P1: w_mb = c_M_W'(r_q1);
            S_P2: begin
                w_ma = c_M_W'(r_q2);
                w_mb = c_M_W'(r_q2);
            end
            S_P3: w_mb = c_M_W'(r_q2);
            S_P4: w_ma = c_M_W'(r_m3);
            default: ;
        endcase
    end

    assign w_prod    = w_ma * w_mb;
    assign w_prod_sh = w_prod >>> COEFF_FRAC;

    assign w_p_sh    = r_p >>> COEFF_FRAC;
    assign w_q0      = c_Q_W'(w_p_sh) - c_Q_W'(r_q2) + c_Q_W'(r_sample);
    assign w_sat     = w_q0[c_Q_W-1:STATE_W-1] != {3{w_q0[c_Q_W-1]}};
    assign w_q0_clip = !w_sat ? STATE_W'(w_q0) : (w_q0[c_Q_W-1] ? c_Q_MIN : c_Q_MAX);

    // Power is formed at the P4 edge so it is visible together with the P5 pulse.
    assign w_r     = c_R_W'(r_m1) + c_R_W'(r_m2) - c_R_W'(w_prod_sh);
    assign w_r_x   = c_RX_W'(w_r);
    assign w_clamp = !w_r_x[c_RX_W-1] && (w_r_x > c_PMAX);
    assign w_pow   = w_r_x[c_RX_W-1] ? '0 : (w_clamp ? '1 : POWER_W'(w_r_x));

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_sample  <= '0;
            r_coeff   <= '0;
            r_q1      <= '0;
            r_q2      <= '0;
            r_cnt     <= '0;
            r_p       <= '0;
            r_m1      <= '0;
            r_m2      <= '0;
            r_m3      <= '0;
            r_blk_ovf <= 1'b0;
            r_power   <= '0;
            r_pv      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_pv <= 1'b0;
            if (clear) begin
                r_q1      <= '0;
                r_q2      <= '0;
                r_cnt     <= '0;
                r_blk_ovf <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: if (sample_valid) begin
                        r_sample <= sample;
                        if (r_cnt == '0) r_coeff <= coeff;
                    end
                    S_MUL: r_p <= c_P_W'(w_prod);
                    S_UPD: begin
                        r_q2 <= r_q1;
                        r_q1 <= w_q0_clip;
                        if (w_sat) r_blk_ovf <= 1'b1;
                        if (r_cnt != c_LAST) r_cnt <= r_cnt + 1'b1;
                    end
                    S_P1: r_m1 <= c_MM_W'(w_prod);
                    S_P2: r_m2 <= c_MM_W'(w_prod);
                    S_P3: r_m3 <= c_MM_W'(w_prod);
                    S_P4: begin
                        r_power <= w_pow;
                        r_ovf   <= r_blk_ovf | w_clamp;
                        r_pv    <= 1'b1;
                    end
                    S_P5: begin
                        r_q1      <= '0;
                        r_q2      <= '0;
                        r_cnt     <= '0;
                        r_blk_ovf <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_goertzel_fx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_goertzel_fx
// Brief    : Directed self-checking bench for goertzel_fx (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_goertzel_fx;

    logic               clock = 1'b0;
    logic               aclr, clear;
    logic               sample_valid, sample_valid_s;
    logic               sample_ready, sample_ready_s;
    logic signed [15:0] sample;
    logic signed [17:0] coeff;
    logic [79:0]        power;
    logic [39:0]        power_s;
    logic               pv, pv_s, ovf, ovf_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    goertzel_fx #(.BLOCK_LEN(4)) dut (
        .clock(clock), .aclr(aclr), .clear(clear),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample(sample), .coeff(coeff),
        .power(power), .power_valid(pv), .overflow(ovf)
    );

    goertzel_fx #(.STATE_W(20), .BLOCK_LEN(8)) dut_s (
        .clock(clock), .aclr(aclr), .clear(clear),
        .sample_valid(sample_valid_s), .sample_ready(sample_ready_s),
        .sample(sample), .coeff(coeff),
        .power(power_s), .power_valid(pv_s), .overflow(ovf_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference Goertzel with saturating state and clamped power.
    function automatic logic [127:0] model(input int sw, input int n, input int c,
                                           input int smp[16], output bit mo);
        logic signed [127:0] q0, q1, q2, cc, ss, mx, mn, t, r, pmax;
        mo = 1'b0; q1 = '0; q2 = '0; cc = 128'(c);
        mx = (128'sd1 <<< (sw-1)) - 128'sd1;
        mn = -mx - 128'sd1;
        for (int i = 0; i < n; i++) begin
            ss = 128'(smp[i]);
            q0 = ((cc * q1) >>> 16) - q2 + ss;
            if (q0 > mx) begin q0 = mx; mo = 1'b1; end
            if (q0 < mn) begin q0 = mn; mo = 1'b1; end
            q2 = q1; q1 = q0;
        end
        t    = ((q1 * q2) * cc) >>> 16;
        r    = q1*q1 + q2*q2 - t;
        pmax = (128'sd1 <<< (2*sw)) - 128'sd1;
        if (r < 0) return '0;
        if (r > pmax) begin mo = 1'b1; return pmax; end
        return r;
    endfunction

    task automatic send(input bit s, input int v);
        int k = 0;
        @(negedge clock);
        while (!(s ? sample_ready_s : sample_ready) && k < 30) begin
            @(negedge clock);
            k++;
        end
        if (k >= 30) check("ready_timeout", 0, 1);
        sample = 16'(v);
        if (s) sample_valid_s = 1'b1; else sample_valid = 1'b1;
        @(negedge clock);
        sample_valid   = 1'b0;
        sample_valid_s = 1'b0;
    endtask

    task automatic run_block(input bit s, input int n, input int smp[16], input int c0,
                             input int c1, input logic [127:0] exp_pw, input bit exp_ov,
                             input string tag);
        int  k = 0;
        bit  seen = 1'b0;
        coeff = 18'(c0);
        for (int i = 0; i < n; i++) begin
            send(s, smp[i]);
            coeff = 18'(c1);
        end
        while (k < 20 && !seen) begin
            @(negedge clock);
            k++;
            seen = s ? pv_s : pv;
        end
        check({tag, "_pv_seen"}, 128'(seen), 1);
        check({tag, "_latency"}, 128'(k), 6);
        check({tag, "_power"}, s ? 128'(power_s) : 128'(power), exp_pw);
        check({tag, "_ovf"}, s ? 128'(ovf_s) : 128'(ovf), 128'(exp_ov));
        @(negedge clock);
        check({tag, "_pv_pulse"}, s ? 128'(pv_s) : 128'(pv), 0);
    endtask

    initial begin
        int          smp[16];
        int          st[16];
        int          acc_t[8];
        logic [127:0] pws[2];
        logic [127:0] e;
        bit          mo;
        int          idx, cyc, npv, nbad;

        aclr = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample_valid_s = 1'b0;
        sample = '0; coeff = '0;
        #22;
        check("rst_power", 128'(power), 0);
        check("rst_pv", 128'(pv), 0);
        check("rst_ovf", 128'(ovf), 0);
        @(negedge clock);
        aclr = 1'b0;
        #1 check("rst_ready", 128'(sample_ready), 1);

        smp = '{default:0}; smp[0] = 1;
        run_block(0, 4, smp, 'h10000, 'h10000, 1, 0, "impulse");
        smp = '{default:0}; smp[0] = 3;
        run_block(0, 4, smp, 0, 'h10000, 9, 0, "coeff0");
        smp[1] = 1;
        run_block(0, 4, smp, 0, 'h10000, 10, 0, "coeff_latch");

        // Abort in P3, with a competing sample offered while clear is high.
        coeff = 18'h10000;
        send(0, 1); send(0, 0); send(0, 0); send(0, 0);
        repeat (4) @(negedge clock);
        clear = 1'b1; sample = 16'sd7; sample_valid = 1'b1;
        @(negedge clock);
        check("clear_ready", 128'(sample_ready), 0);
        @(negedge clock);
        clear = 1'b0; sample_valid = 1'b0;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (pv) nbad++;
        end
        check("clear_no_pv", 128'(nbad), 0);
        check("clear_power_hold", 128'(power), 10);
        smp = '{default:0}; smp[0] = 2;
        run_block(0, 4, smp, 'h10000, 'h10000, 4, 0, "after_clear");

        // Saturation on the narrow-state instance, then a clean block.
        for (int i = 0; i < 8; i++) smp[i] = 32767;
        e = model(20, 8, 'h1FFFF, smp, mo);
        check("sat_model_ovf", 128'(mo), 1);
        run_block(1, 8, smp, 'h1FFFF, 'h1FFFF, e, 1, "sat");
        smp = '{default:0}; smp[0] = 1;
        e = model(20, 8, 'h10000, smp, mo);
        run_block(1, 8, smp, 'h10000, 'h10000, e, 0, "sat_clean");

        // Continuous sample_valid across two blocks.
        smp = '{5, -3, 7, 2, -8, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        coeff = 18'h0C000;
        idx = 0; cyc = 0; npv = 0;
        while (cyc < 80 && (idx < 8 || npv < 2)) begin
            @(negedge clock);
            cyc++;
            if (pv) begin
                if (npv < 2) pws[npv] = 128'(power);
                npv++;
            end
            if (idx < 8) begin
                sample = 16'(smp[idx]);
                sample_valid = 1'b1;
                if (sample_ready) begin
                    acc_t[idx] = cyc;
                    idx++;
                end
            end else begin
                sample_valid = 1'b0;
            end
        end
        sample_valid = 1'b0;
        check("stream_accepts", 128'(idx), 8);
        check("stream_npv", 128'(npv), 2);
        for (int i = 1; i < 8; i++)
            check($sformatf("stream_gap%0d", i), 128'(acc_t[i] - acc_t[i-1]), (i == 4) ? 8 : 3);
        st = '{default:0};
        for (int i = 0; i < 4; i++) st[i] = smp[i];
        check("stream_blk0", pws[0], model(40, 4, 'hC000, st, mo));
        for (int i = 0; i < 4; i++) st[i] = smp[i+4];
        check("stream_blk1", pws[1], model(40, 4, 'hC000, st, mo));

        // Asynchronous reset mid-block.
        coeff = 18'h10000;
        send(0, 5); send(0, 1);
        #2 aclr = 1'b1;
        #1;
        check("aclr_power", 128'(power), 0);
        check("aclr_pv", 128'(pv), 0);
        check("aclr_ovf", 128'(ovf), 0);
        check("aclr_ready", 128'(sample_ready), 1);
        @(negedge clock);
        aclr = 1'b0;
        smp = '{default:0}; smp[0] = 4; smp[1] = -2; smp[3] = 1;
        run_block(0, 4, smp, 'h10000, 'h10000, model(40, 4, 'h10000, smp, mo), 0, "post_aclr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
